hash_sched: RTL and testbench
=============================

Name: hash_sched

Overview:
- Arbitrates between two key requesters (query path = 0, update path = 1) and drives one shared instance of the team's 32-bit-per-cycle CRC-32 engine (`crc`).
- Each requester sends a key as a stream of 32-bit words. The block hashes the whole key and returns a truncated hash tagged with the requester id.
- It sits between the packet parsers and the KV table address logic.

Parameters:
- MAX_WORDS, 16, maximum number of key words folded into the hash. Later words are consumed but not hashed.
- HASH_BITS, 20, width of the returned hash; the low bits of the CRC are used; legal range 1..32.
- CNT_W, 5, width of the word counter; must satisfy 2^CNT_W > MAX_WORDS.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- s0_valid  in  1  requester 0 word valid
- s0_data  in  32  requester 0 key word
- s0_last  in  1  requester 0 final word of key
- s0_ready  out  1  requester 0 word accepted
- s1_valid  in  1  requester 1 word valid
- s1_data  in  32  requester 1 key word
- s1_last  in  1  requester 1 final word of key
- s1_ready  out  1  requester 1 word accepted
- m_valid  out  1  hash result valid
- m_hash  out  HASH_BITS  crc[HASH_BITS-1:0]
- m_id  out  1  requester that owns the result
- m_ovf  out  1  key exceeded MAX_WORDS
- m_ready  in  1  consumer accepts result
- busy  out  1  state != IDLE

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-low. rst_n is sampled only on the rising edge of clk.
- Reset values:
  - state = IDLE; rr_ptr = 0.
  - s0_ready = s1_ready = 0.
  - m_valid = 0, m_hash = 0, m_id = 0, m_ovf = 0, busy = 0.
  - CRC init pulse asserted during reset.
- CRC engine:
  - Instance of `crc` with crc_en = (granted sN_valid && sN_ready).
  - Its rst input is driven from a registered init pulse, which loads 0xFFFFFFFF.
  - No reflection and no final XOR.
  - crc_out reflects a word on the cycle after that word's handshake.
- IDLE:
  - If exactly one of s0_valid/s1_valid is high, grant it.
  - If both are high, grant the requester != rr_ptr's last winner. Grant 0 when rr_ptr = 1, grant 1 when rr_ptr = 0.
  - Latch gnt, clear cnt and ovf, go to INIT.
- INIT (1 cycle): init pulse = 1; no ready asserted; go to FEED.
- FEED:
  - s{gnt}_ready = 1; the other ready = 0.
  - On each handshake: cnt <= sat(cnt+1).
  - Words with cnt < MAX_WORDS drive crc_en = 1.
  - Words with cnt >= MAX_WORDS: crc_en = 0 and ovf <= 1.
  - A handshake with last = 1 goes to OUT.
- OUT:
  - On entry, register m_hash = crc_out[HASH_BITS-1:0], m_id = gnt, m_ovf = ovf, and m_valid = 1.
  - Hold all values while m_ready = 0.
  - On m_valid && m_ready: m_valid <= 0, rr_ptr <= gnt, go to IDLE.
- Latency: first word valid in cycle 0 (IDLE) → INIT in cycle 1 → first accept in cycle 2. For an N-word key with no stalls, last accept is in cycle N+1 and m_valid is high in cycle N+2.
- Minimum overhead is 3 non-feeding cycles per key.
- Source stalls: sN_valid low in FEED inserts wait cycles; CRC state is held.
- Ungranted requester: ready stays 0 for the whole transaction. Its valid/data must be held by the source, per standard valid/ready rules.
- A 1-word key (first word has last = 1) is legal: FEED lasts one cycle.
- Reset mid-operation: rst_n low in any state returns to the reset values on the next edge. Any partial key is discarded and the CRC is re-initialised.
- The cnt counter saturates at 2^CNT_W - 1, so no wrap occurs.

Test Plan:
- Requester 0 sends single word 0x00000000, last = 1, m_ready = 1 → m_valid in cycle 3, m_hash = 0x4DD7B (crc 0xC704DD7B), m_id = 0, m_ovf = 0.
- s0 and s1 valid together from reset, each with a 2-word key → s1 is granted first (rr_ptr = 0 prefers 1), then s0. m_id sequence is 1, 0. s0_ready stays 0 throughout the s1 transaction.
- 20-word key on s1 with MAX_WORDS = 16 → all 20 words accepted; m_ovf = 1; m_hash equals the reference CRC of the first 16 words only.
- m_ready held low for 10 cycles in OUT → m_valid, m_hash and m_id are stable for those cycles; no s*_ready is asserted; busy = 1.
- s0_valid toggled 0/1 every other cycle during a 4-word key → result equals the no-stall run; completion is delayed by the number of stall cycles.
- rst_n low for 1 cycle during FEED word 2 of a 4-word key → all outputs return to reset values. A following fresh 1-word 0x00000000 key returns 0x4DD7B.

Source files
------------

// File: rtl/hash_sched.sv
// Two-requester key hasher sharing one 32-bit-per-cycle CRC-32 engine.
// Returns the low HASH_BITS of the CRC, tagged with the owning requester.

module crc #(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             crc_en,
  input  logic [31:0]      data_in,
  output logic [OUT_W-1:0] crc_out
);

  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic [31:0] q;

  function automatic logic [31:0] step(
    input logic [31:0] c,
    input logic [31:0] d
  );
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ POLY;
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)
      q <= 32'hFFFF_FFFF;
    else if (crc_en)
      q <= step(q, data_in);
  end

  assign crc_out = q[OUT_W-1:0];

endmodule

module hash_sched #(
  parameter int MAX_WORDS = 16,
  parameter int HASH_BITS = 20,
  parameter int CNT_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s0_valid,
  input  logic [31:0]          s0_data,
  input  logic                 s0_last,
  output logic                 s0_ready,
  input  logic                 s1_valid,
  input  logic [31:0]          s1_data,
  input  logic                 s1_last,
  output logic                 s1_ready,
  output logic                 m_valid,
  output logic [HASH_BITS-1:0] m_hash,
  output logic                 m_id,
  output logic                 m_ovf,
  input  logic                 m_ready,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    FEED,
    OUT
  } state_t;

  localparam logic [CNT_W-1:0] MAXW = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_t state, state_nxt;

  logic             gnt;
  logic             rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             init_q;
  logic             arb_gnt;
  logic             hs;
  logic             s_last;
  logic [31:0]      s_data;
  logic             in_win;
  logic             crc_en;
  logic [HASH_BITS-1:0] crc_q;

  // Contention goes to whoever did not win last time.
  assign arb_gnt = (s0_valid && s1_valid) ? ~rr_ptr : s1_valid;

  assign s0_ready = (state == FEED) && !gnt;
  assign s1_ready = (state == FEED) && gnt;
  assign busy     = (state != IDLE);

  assign s_last = gnt ? s1_last : s0_last;
  assign s_data = gnt ? s1_data : s0_data;
  assign hs     = gnt ? (s1_valid && s1_ready)
                      : (s0_valid && s0_ready);
  assign in_win = (cnt < MAXW);
  assign crc_en = hs && in_win;

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (s0_valid || s1_valid) state_nxt = INIT;
      INIT: state_nxt = FEED;
      FEED: if (hs && s_last) state_nxt = OUT;
      OUT:  if (m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt     <= 1'b0;
      rr_ptr  <= 1'b0;
      cnt     <= '0;
      ovf     <= 1'b0;
      init_q  <= 1'b1;
      m_valid <= 1'b0;
      m_id    <= 1'b0;
      m_ovf   <= 1'b0;
    end else begin
      init_q <= (state_nxt == INIT);
      if (state == IDLE && state_nxt == INIT) begin
        gnt <= arb_gnt;
        cnt <= '0;
        ovf <= 1'b0;
      end
      if (hs) begin
        if (cnt != CMAX) cnt <= cnt + 1'b1;
        if (!in_win) ovf <= 1'b1;
      end
      if (hs && s_last) begin
        m_valid <= 1'b1;
        m_id    <= gnt;
        m_ovf   <= ovf | ~in_win;
      end
      if (state == OUT && m_ready) begin
        m_valid <= 1'b0;
        rr_ptr  <= gnt;
      end
    end
  end

  crc #(
    .OUT_W(HASH_BITS)
  ) u_crc (
    .clk    (clk),
    .rst    (init_q),
    .crc_en (crc_en),
    .data_in(s_data),
    .crc_out(crc_q)
  );

  // CRC register is frozen in OUT, so it doubles as the result register.
  assign m_hash = m_valid ? crc_q : '0;

endmodule

// File: tb/tb_hash_sched.sv
// Self-checking bench for hash_sched: vector table, corner sequences,
// and randomized keys against a polynomial-division CRC model.

module tb_hash_sched;

  localparam int MAXW = 16;
  localparam int HB   = 20;

  logic          clk = 0;
  logic          rst_n;
  logic          s0_valid, s0_last, s0_ready;
  logic [31:0]   s0_data;
  logic          s1_valid, s1_last, s1_ready;
  logic [31:0]   s1_data;
  logic          m_valid, m_id, m_ovf, m_ready, busy;
  logic [HB-1:0] m_hash;

  int total = 0;
  int bad   = 0;

  logic [31:0] keybuf [0:31];

  hash_sched #(
    .MAX_WORDS(MAXW),
    .HASH_BITS(HB),
    .CNT_W(5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s0_valid(s0_valid),
    .s0_data (s0_data),
    .s0_last (s0_last),
    .s0_ready(s0_ready),
    .s1_valid(s1_valid),
    .s1_data (s1_data),
    .s1_last (s1_last),
    .s1_ready(s1_ready),
    .m_valid (m_valid),
    .m_hash  (m_hash),
    .m_id    (m_id),
    .m_ovf   (m_ovf),
    .m_ready (m_ready),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Word-wise CRC as polynomial arithmetic: c' = ((c ^ w) * x^32) mod P.
  function automatic logic [31:0] ref_crc(input int n);
    logic [31:0] c;
    logic [63:0] r;
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < n && k < MAXW; k++) begin
      r = {c ^ keybuf[k], 32'h0};
      for (int b = 63; b >= 32; b--)
        if (r[b]) r = r ^ (64'h1_04C1_1DB7 << (b - 32));
      c = r[31:0];
    end
    return c;
  endfunction

  function automatic logic [HB-1:0] ref_hash(input int n);
    logic [31:0] c;
    c = ref_crc(n);
    return c[HB-1:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit id, input logic v, input logic [31:0] d,
                       input logic l);
    if (id) begin
      s1_valid = v; s1_data = d; s1_last = l;
    end else begin
      s0_valid = v; s0_data = d; s0_last = l;
    end
  endtask

  // Called at #1 after an edge with the DUT idle; cycle 0 is the first
  // cycle with valid high.
  task automatic run_key(input bit id, input int n, input bit stall,
                         input int hold, input logic [HB-1:0] exp_h,
                         input bit exp_ovf, input int exp_lat,
                         input string tag);
    int  i = 0;
    int  cyc = 0;
    bit  hs;
    bit  other_rdy = 0;
    logic [HB-1:0] h0;
    logic          id0;
    while (i < n && cyc < 400) begin
      drive(id, !stall || (cyc % 2 == 0), keybuf[i], i == n - 1);
      hs = (id ? (s1_valid && s1_ready) : (s0_valid && s0_ready));
      if (id ? s0_ready : s1_ready) other_rdy = 1;
      tick();
      if (hs) i++;
      cyc++;
    end
    if (i < n) begin
      chk({tag, "_feed_timeout"}, 1, 0);
      drive(id, 0, 0, 0);
      return;
    end
    drive(id, 0, 0, 0);
    chk({tag, "_other_ready"}, other_rdy, 0);
    chk({tag, "_latency"}, m_valid ? cyc : -1, exp_lat);
    while (!m_valid && cyc < 400) begin
      tick();
      cyc++;
    end
    if (!m_valid) begin
      chk({tag, "_out_timeout"}, 1, 0);
      return;
    end
    h0  = m_hash;
    id0 = m_id;
    for (int k = 0; k < hold; k++) begin
      tick();
      chk({tag, "_hold"}, {m_valid, m_hash, m_id, s0_ready, s1_ready, busy},
          {1'b1, h0, id0, 1'b0, 1'b0, 1'b1});
    end
    chk({tag, "_hash"}, m_hash, exp_h);
    chk({tag, "_id"}, m_id, id);
    chk({tag, "_ovf"}, m_ovf, exp_ovf);
    m_ready = 1;
    tick();
    m_ready = 0;
    chk({tag, "_drain"}, {m_valid, busy}, 2'b00);
  endtask

  typedef struct {
    bit          id;
    int          n;
    bit          stall;
    int          hold;
    logic [31:0] w0;
    logic [31:0] step;
    logic [HB-1:0] exp_h;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs [0:6];

  task automatic fill(input logic [31:0] w0, input logic [31:0] st,
                      input int n);
    for (int k = 0; k < n; k++) keybuf[k] = w0 + st * k;
  endtask

  initial begin
    rst_n = 0; m_ready = 0;
    s0_valid = 0; s0_data = 0; s0_last = 0;
    s1_valid = 0; s1_data = 0; s1_last = 0;

    vecs[0] = '{0, 1, 0, 0, 32'h0, 32'h0, 20'h4DD7B, 0};
    vecs[1] = '{1, 20, 0, 0, 32'h1234_5678, 32'h0101_0101, 0, 1};
    vecs[2] = '{0, 4, 0, 10, 32'hDEAD_BEEF, 32'h1111_0001, 0, 0};
    vecs[3] = '{0, 4, 1, 0, 32'hDEAD_BEEF, 32'h1111_0001, 0, 0};
    vecs[4] = '{1, 16, 0, 1, 32'hA5A5_0000, 32'h0000_0003, 0, 0};
    vecs[5] = '{1, 17, 0, 0, 32'hA5A5_0000, 32'h0000_0003, 0, 1};
    vecs[6] = '{0, 2, 0, 2, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0};
    for (int v = 1; v < 7; v++) begin
      fill(vecs[v].w0, vecs[v].step, vecs[v].n);
      vecs[v].exp_h = ref_hash(vecs[v].n);
    end

    tick(); tick();
    chk("rst_out", {s0_ready, s1_ready, m_valid, m_hash, m_id, m_ovf, busy},
        '0);
    rst_n = 1;
    tick();

    // s0 and s1 contend from reset: s1 wins, s0 ready stays low.
    s0_valid = 1; s0_data = 32'h0BAD_F00D; s0_last = 0;
    keybuf[0] = 32'h1; keybuf[1] = 32'h2;
    run_key(1, 2, 0, 0, ref_hash(2), 0, 4, "rr_s1");
    keybuf[0] = 32'h0BAD_F00D; keybuf[1] = 32'h3;
    run_key(0, 2, 0, 0, ref_hash(2), 0, 4, "rr_s0");

    for (int v = 0; v < 7; v++) begin
      fill(vecs[v].w0, vecs[v].step, vecs[v].n);
      run_key(vecs[v].id, vecs[v].n, vecs[v].stall, vecs[v].hold,
              vecs[v].exp_h, vecs[v].exp_ovf,
              vecs[v].stall ? 2 * vecs[v].n + 1 : vecs[v].n + 2,
              $sformatf("vec%0d", v));
    end

    // Reset during FEED of a 4-word key, then a fresh zero word.
    fill(32'h5555_0000, 32'h7, 4);
    s0_valid = 1; s0_data = keybuf[0]; s0_last = 0;
    tick(); tick(); tick();
    s0_data = keybuf[1];
    chk("mid_in_feed", s0_ready, 1);
    rst_n = 0;
    tick();
    rst_n = 1;
    s0_valid = 0;
    chk("mid_rst", {s0_ready, s1_ready, m_valid, m_hash, m_id, m_ovf, busy},
        '0);
    keybuf[0] = 32'h0;
    run_key(0, 1, 0, 0, 20'h4DD7B, 0, 3, "post_rst");

    // Randomized keys against the model.
    for (int r = 0; r < 25; r++) begin
      int  n;
      bit  id;
      bit  st;
      n  = $urandom_range(1, 22);
      id = 1'($urandom_range(0, 1));
      st = 1'($urandom_range(0, 1));
      for (int k = 0; k < n; k++) keybuf[k] = $urandom;
      run_key(id, n, st, $urandom_range(0, 3), ref_hash(n), n > MAXW,
              st ? 2 * n + 1 : n + 2, $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
